// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//   Two-digit multiplexed 7-segment driver for a 0..19 BCD value.
//   A one-deep pending register accepts values from the source with a
//   valid/ready handshake. The display register only updates at a frame
//   boundary (end of the tens slot), so a frame never shows a mix of two values.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   bcd_valid  source offers bcd this cycle
//   bcd[4:0]   bit4 = tens digit (0/1), bits3:0 = units digit
//   bcd_ready  high when the pending register is empty
//   seg[6:0]   active-low segments, seg[0]=a .. seg[6]=g (registered)
//   an[1:0]    active-low digit enables, an[0]=units, an[1]=tens (registered)
//   err        sticky: a units digit above 9 was accepted
//
// Parameter
//   REFRESH_DIV  clk cycles each digit is driven per scan slot (1..2^20)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked
// ---------------------------------------------------------------------------
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bcd_valid,
  input  logic [4:0] bcd,
  output logic       bcd_ready,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_ONE  = 7'b1111001;

  typedef enum logic {
    SCAN_UNITS = 1'b0,
    SCAN_TENS  = 1'b1
  } scan_state_t;

  logic [DIV_W-1:0] div_q, div_d;
  scan_state_t      state_q, state_d;
  logic [4:0]       disp_q, disp_d;
  logic [4:0]       pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             err_q, err_d;

  logic div_tc;
  logic frame_edge;
  logic accept;

  // Units digit pattern; 10..15 are not decimal digits and show a dash.
  function automatic logic [6:0] units_seg(input logic [3:0] u);
    logic [6:0] s;
    case (u)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    div_tc     = (div_q == DIV_LAST);
    div_d      = div_tc ? '0 : div_q + DIV_W'(1);

    state_d    = state_q;
    if (div_tc) begin
      state_d = (state_q == SCAN_UNITS) ? SCAN_TENS : SCAN_UNITS;
    end

    // Frame boundary = leaving the tens slot.
    frame_edge = div_tc && (state_q == SCAN_TENS);
    accept     = bcd_valid && !pend_q;

    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;

    // Commit uses the pending value as it stood before this edge. A value
    // accepted on this same edge can only arrive when pend_q was 0, so it is
    // never committed here and waits for the following boundary.
    if (frame_edge && pend_q) begin
      disp_d = pend_val_q;
      pend_d = 1'b0;
    end
    if (accept) begin
      pend_d     = 1'b1;
      pend_val_d = bcd;
    end

    err_d = err_q | (accept && (bcd[3:0] > 4'd9));

    // Outputs follow the current state/display one cycle later.
    if (state_q == SCAN_UNITS) begin
      an_d  = 2'b10;
      seg_d = units_seg(disp_q[3:0]);
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (disp_q[4]) begin
        an_d  = 2'b01;
        seg_d = SEG_ONE;
      end else begin
        an_d  = 2'b11;
        seg_d = SEG_OFF;
      end
`else
      an_d  = 2'b01;
      seg_d = disp_q[4] ? SEG_ONE : SEG_ZERO;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      state_q    <= SCAN_UNITS;
      disp_q     <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= 2'b11;
      err_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      err_q      <= err_d;
    end
  end

  assign bcd_ready = !pend_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Directed plus random stimulus for bcd_seg_scan with REFRESH_DIV=4.
//   The reference model works in terms of "edges since reset release":
//   slot = (edges/4) % 2 picks units/tens, every 8th edge is a frame boundary,
//   and the visible outputs lag that slot/display by one edge.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bcd_valid;
  logic [4:0] bcd;
  logic       bcd_ready;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int tests = 0;
  int fails = 0;

  // reference model state
  int         m_e;
  logic       m_pend;
  logic [4:0] m_pval;
  logic [4:0] m_disp;
  logic       m_err;
  logic [6:0] m_seg;
  logic [1:0] m_an;

  bcd_seg_scan #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_valid (bcd_valid),
    .bcd       (bcd),
    .bcd_ready (bcd_ready),
    .seg       (seg),
    .an        (an),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pattern(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;  1: s = 7'b1111001;
      2: s = 7'b0100100;  3: s = 7'b0110000;
      4: s = 7'b0011001;  5: s = 7'b0010010;
      6: s = 7'b0000010;  7: s = 7'b1111000;
      8: s = 7'b0000000;  9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    m_e = 0; m_pend = 1'b0; m_pval = '0; m_disp = '0; m_err = 1'b0;
    m_seg = 7'b1111111; m_an = 2'b11;
  endtask

  // One rising edge of the model, using the inputs presented on that edge.
  task automatic model_edge(input logic v, input logic [4:0] d);
    int   slot;
    int   tens;
    logic acc;
    slot = (m_e / DIV) % 2;
    tens = int'(m_disp[4]);
    if (slot == 0) begin
      m_an  = 2'b10;
      m_seg = digit_pattern(int'(m_disp[3:0]));
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      m_an  = (tens == 0) ? 2'b11 : 2'b01;
      m_seg = (tens == 0) ? 7'b1111111 : digit_pattern(tens);
`else
      m_an  = 2'b01;
      m_seg = digit_pattern(tens);
`endif
    end
    acc = v && !m_pend;
    m_e = m_e + 1;
    if ((m_e % (2 * DIV)) == 0 && m_pend) begin
      m_disp = m_pval;
      m_pend = 1'b0;
    end
    if (acc) begin
      m_pend = 1'b1;
      m_pval = d;
      if (d[3:0] > 4'd9) m_err = 1'b1;
      $display("[TB] edge %0d accept bcd=%b", m_e, d);
    end else if (v) begin
      $display("[TB] edge %0d drop   bcd=%b (pending)", m_e, d);
    end
  endtask

  task automatic check_all(input string tag);
    tests++;
    assert (seg === m_seg) else begin
      fails++; $error("FAIL %s seg edge=%0d got=%b exp=%b", tag, m_e, seg, m_seg);
    end
    tests++;
    assert (an === m_an) else begin
      fails++; $error("FAIL %s an edge=%0d got=%b exp=%b", tag, m_e, an, m_an);
    end
    tests++;
    assert (bcd_ready === !m_pend) else begin
      fails++; $error("FAIL %s ready edge=%0d got=%b exp=%b", tag, m_e, bcd_ready, !m_pend);
    end
    tests++;
    assert (err === m_err) else begin
      fails++; $error("FAIL %s err edge=%0d got=%b exp=%b", tag, m_e, err, m_err);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Called at a negedge: present inputs, take one edge, check at next negedge.
  task automatic cycle(input logic v, input logic [4:0] d, input string tag);
    bcd_valid = v;
    bcd       = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    bcd_valid = 1'b0;
    check_all(tag);
  endtask

  // Idle until the edge count modulo one frame equals p (model-driven, bounded).
  task automatic run_to_phase(input int p);
    for (int i = 0; i < 2 * DIV; i++) begin
      cycle(1'b0, 5'd0, "idle");
      if ((m_e % (2 * DIV)) == p) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; bcd_valid = 1'b0; bcd = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset_hold");

    // release; first edge must show "00" in the units slot
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, "first_edge");
    check_val("first_an", {6'd0, an}, 8'b10);
    check_val("first_seg", {1'b0, seg}, {1'b0, 7'b1000000});

    // idle scanning, digits alternate every 4 cycles
    for (int i = 0; i < 16; i++) cycle(1'b0, 5'd0, "idle_scan");
    run_to_phase(6);
    check_val("idle_tens_an", {6'd0, an}, 8'b01);

    // value 15 accepted mid units slot, then 3 offered while pending
    run_to_phase(1);
    cycle(1'b1, 5'b10101, "acc15");
    check_val("ready_low", {7'd0, bcd_ready}, 8'd0);
    cycle(1'b1, 5'b00011, "drop3");
    run_to_phase(0);
    run_to_phase(2);
    check_val("u15_seg", {1'b0, seg}, {1'b0, 7'b0010010});
    check_val("ready_back", {7'd0, bcd_ready}, 8'd1);
    run_to_phase(6);
    check_val("t15_seg", {1'b0, seg}, {1'b0, 7'b1111001});
    check_val("t15_err", {7'd0, err}, 8'd0);

    // invalid units digit 12, then valid 9
    cycle(1'b1, 5'b01100, "acc12");
    check_val("err_set", {7'd0, err}, 8'd1);
    run_to_phase(0);
    run_to_phase(2);
    check_val("u12_dash", {1'b0, seg}, {1'b0, 7'b0111111});
    cycle(1'b1, 5'b01001, "acc9");
    run_to_phase(0);
    run_to_phase(2);
    check_val("u9_seg", {1'b0, seg}, {1'b0, 7'b0010000});
    check_val("err_sticky", {7'd0, err}, 8'd1);

    // value 7 with tens 0: leading-zero handling
    cycle(1'b1, 5'b00111, "acc7");
    run_to_phase(0);
    run_to_phase(2);
    check_val("u7_seg", {1'b0, seg}, {1'b0, 7'b1111000});
    run_to_phase(6);
`ifdef LEADING_ZERO_BLANK_EN
    check_val("t0_an", {6'd0, an}, 8'b11);
    check_val("t0_seg", {1'b0, seg}, {1'b0, 7'b1111111});
`else
    check_val("t0_an", {6'd0, an}, 8'b01);
    check_val("t0_seg", {1'b0, seg}, {1'b0, 7'b1000000});
`endif

    // reset pulse mid-frame with a value pending
    run_to_phase(3);
    cycle(1'b1, 5'b11000, "acc18");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("reset_pulse");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 5'd0, "post_reset");
    run_to_phase(2);
    check_val("post_reset_u", {1'b0, seg}, {1'b0, 7'b1000000});

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [4:0] d;
      v = (($urandom % 3) == 0);
      d = {1'($urandom % 2), 4'($urandom % 16)};
      cycle(v, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
